mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the datapath's MAR/MDR interface. It accepts read and write requests driven by the control sequencer through `Read`/`Write`, the MAR address and the MDR contents. It services them from an internal word-addressed RAM after a configurable number of wait states, and acknowledges with `Done`. On reads it drives the `Mdatain` word that the datapath loads into MDR.

## Interface
- `ADDR_W`, 9: address width; RAM depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: wait states inserted between request capture and acknowledge; legal range 0..15.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Clear`  in  1  reset, asynchronous, active-low.
- `Read`  in  1  read request from the control sequencer; level, held until `Done`.
- `Write`  in  1  write request from the control sequencer; level, held until `Done`.
- `MAR_addr`  in  ADDR_W  word address, taken from the low bits of MAR.
- `MDR_data`  in  32  write data from MDR.
- `Mdatain`  out  32  read data to the MDR input mux; registered.
- `Done`  out  1  acknowledge; registered.
- `Err`  out  1  sticky protocol-error flag; registered.

## Operation
- FSM states are IDLE, WAIT and ACK. All outputs are registered.
- **IDLE**
  - On an edge with `Read` or `Write` high, latch `MAR_addr`, `MDR_data` and the operation type.
  - If `WAIT_CYCLES` = 0, go to ACK; otherwise go to WAIT with counter = `WAIT_CYCLES`.
- **WAIT**
  - The counter decrements each edge.
  - On the edge where the counter is 1, go to ACK.
  - Request inputs are ignored during WAIT.
- **Entry to ACK** (the same edge as the transition)
  - Read: `Mdatain` <= RAM[latched addr].
  - Write: RAM[latched addr] <= latched data; `Mdatain` unchanged.
  - `Done` <= 1.
- **ACK**
  - Four-phase handshake: stay in ACK with `Done` = 1 while `Read` or `Write` is high.
  - On the first edge with both low, go to IDLE with `Done` <= 0.
- **Simultaneous `Read` and `Write` in IDLE:** the request executes as a read, the write is discarded, and `Err` <= 1. `Err` is cleared only by `Clear`.
- **Request dropped during WAIT:** the transaction still commits. ACK then lasts exactly one cycle, so `Done` is a 1-cycle pulse.
- `Mdatain` holds the last read value indefinitely; a write never disturbs it.
- RAM contents are not affected by `Clear` and are undefined after power-up. The bench initialises the RAM through writes.
- Addresses wrap naturally at ADDR_W bits; no range error exists.

## Timing
- **Reset values:** `Mdatain` = 32'h00000000, `Done` = 0, `Err` = 0, state = IDLE, counter = 0.
- **`Clear` low:** forces reset values immediately, independent of `Clock`.
- **`Clear` low mid-WAIT:** a pending write is aborted and the RAM is not modified.
- **`Clear` low during ACK:** a completed write remains in the RAM.
- **Latency:** request sampled at edge k gives `Done` and `Mdatain` valid after edge k + `WAIT_CYCLES`. With default 1, that is one cycle after capture.
- **Release:** `Done` falls after the first edge at which `Read` = `Write` = 0.
- **Next request:** the earliest new request is sampled on the edge after returning to IDLE, giving a minimum of one idle cycle between transactions.
- **Address/data stability:** `MAR_addr` and `MDR_data` need only be stable at the capture edge. Changes during WAIT or ACK have no effect.

## Test plan
- **Reset:** `Clear` low for 2 cycles, then high -> `Mdatain` = 0, `Done` = 0, `Err` = 0. No RAM access occurs while `Read`/`Write` stay low.
- **Write then read, default WAIT_CYCLES = 1:**
  - Write 32'h4A920000 to address 9'h010 -> `Done` high 1 cycle after capture and held until `Write` drops.
  - Read 9'h010 -> `Mdatain` = 32'h4A920000 together with `Done`.
- **Back-to-back reads, WAIT_CYCLES = 3:** addresses 9'h022 and 9'h024 preloaded with 32'h00000022 and 32'h00000024.
  - Each `Done` arrives 3 edges after capture.
  - `Mdatain` keeps 32'h00000022 until the second ACK, then shows 32'h00000024.
- **Simultaneous request:** `Read` = `Write` = 1 at address 9'h026, which holds 32'h00000026, with `MDR_data` = 32'hFFFFFFFF.
  - `Mdatain` = 32'h00000026 and `Err` = 1.
  - A later read of 9'h026 still returns 32'h00000026.
  - `Err` remains 1 until `Clear`.
- **Reset mid-WAIT:** WAIT_CYCLES = 4, write 32'hDEADBEEF to 9'h030 (previously 32'h12345678), with `Clear` pulsed low during WAIT.
  - `Done` never rises.
  - A subsequent read of 9'h030 returns 32'h12345678.
- **Early release, WAIT_CYCLES = 0:** `Read` drops one cycle after capture -> `Done` is a single-cycle pulse and the FSM is back in IDLE on the next edge.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: word-addressed RAM with a
// level-handshake request, configurable wait states and registered outputs.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [31:0]       MDR_data,
  output logic [31:0]       Mdatain,
  output logic              Done,
  output logic              Err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              rd_q;
  logic [31:0]       mdatain_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       ram_q [DEPTH];

  logic              req;
  logic              commit_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       data_d;
  logic              rd_d;

  assign req = Read | Write;

  // Commit happens on the edge that enters ACK; with zero wait states the
  // live request is committed directly, otherwise the latched one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    commit_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_d     = rd_q;
    if (state_q == ST_IDLE && req && WAIT_CYCLES == 0) begin
      commit_d = 1'b1;
      addr_d   = MAR_addr;
      data_d   = MDR_data;
      rd_d     = Read;
    end else if (state_q == ST_WAIT && cnt_q == 4'd1) begin
      commit_d = 1'b1;
    end
  end

  // NOTE: the RAM array is deliberately not reset; Clear gates the write so a
  // request presented while Clear is low cannot land in memory.
  always_ff @(posedge Clock) begin
    if (Clear && commit_d && !rd_d) begin
      ram_q[addr_d] <= data_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= 32'h0;
      rd_q      <= 1'b0;
      mdatain_q <= 32'h0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q <= MAR_addr;
            data_q <= MDR_data;
            rd_q   <= Read;
            if (Read && Write) begin
              err_q <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!req) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (commit_d) begin
        done_q <= 1'b1;
        if (rd_d) begin
          mdatain_q <= ram_q[addr_d];
        end
      end
    end
  end

  assign Mdatain = mdatain_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: four instances with 0, 1, 3 and 4 wait
// states, each compared against a transaction-level memory model.
module tb_mem_responder;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        rd [4];
  logic        wr [4];
  logic [8:0]  ad [4];
  logic [31:0] dt [4];
  logic [31:0] md [4];
  logic        dn [4];
  logic        er [4];

  localparam int WC [4] = '{0, 1, 3, 4};

  logic [31:0] ram_m [4][512];
  logic [31:0] md_m  [4];
  logic        err_m [4];
  logic [8:0]  pool  [16];

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u_w0 (
    .Clock(Clock), .Clear(Clear), .Read(rd[0]), .Write(wr[0]), .MAR_addr(ad[0]),
    .MDR_data(dt[0]), .Mdatain(md[0]), .Done(dn[0]), .Err(er[0]));
  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(1)) u_w1 (
    .Clock(Clock), .Clear(Clear), .Read(rd[1]), .Write(wr[1]), .MAR_addr(ad[1]),
    .MDR_data(dt[1]), .Mdatain(md[1]), .Done(dn[1]), .Err(er[1]));
  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(3)) u_w3 (
    .Clock(Clock), .Clear(Clear), .Read(rd[2]), .Write(wr[2]), .MAR_addr(ad[2]),
    .MDR_data(dt[2]), .Mdatain(md[2]), .Done(dn[2]), .Err(er[2]));
  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(4)) u_w4 (
    .Clock(Clock), .Clear(Clear), .Read(rd[3]), .Write(wr[3]), .MAR_addr(ad[3]),
    .MDR_data(dt[3]), .Mdatain(md[3]), .Done(dn[3]), .Err(er[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_all();
    for (int d = 0; d < 4; d++) begin
      check("rst_mdatain", md[d], 32'h0);
      check("rst_done", {31'h0, dn[d]}, 32'h0);
      check("rst_err", {31'h0, er[d]}, 32'h0);
      md_m[d]  = 32'h0;
      err_m[d] = 1'b0;
    end
  endtask

  // One full four-phase transaction on instance d, checked against the model.
  task automatic txn(input int d, input logic r, input logic w, input logic [8:0] a,
                     input logic [31:0] v, input logic early);
    int n;
    int hold;
    logic [31:0] prev;
    prev   = md_m[d];
    rd[d]  = r;
    wr[d]  = w;
    ad[d]  = a;
    dt[d]  = v;
    if (r) md_m[d] = ram_m[d][a];
    else   ram_m[d][a] = v;
    if (r && w) err_m[d] = 1'b1;
    tick();
    n = 1;
    ad[d] = 9'($urandom);
    dt[d] = $urandom;
    if (early) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
    while (n < 40) begin
      if (dn[d]) break;
      check("mdatain_wait", md[d], prev);
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(WC[d] + 1));
    check("mdatain", md[d], md_m[d]);
    check("err", {31'h0, er[d]}, {31'h0, err_m[d]});
    if (!early) begin
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        tick();
        check("done_hold", {31'h0, dn[d]}, 32'h1);
      end
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
    tick();
    check("done_fall", {31'h0, dn[d]}, 32'h0);
  endtask

  initial begin
    Clear = 1'b0;
    for (int d = 0; d < 4; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 9'h0; dt[d] = 32'h0;
    end
    for (int i = 0; i < 15; i++) pool[i] = 9'h020 + 9'(i);
    pool[15] = 9'h030;

    tick();
    tick();
    check_reset_all();
    Clear = 1'b1;
    tick();
    check_reset_all();

    // Preload every pool address on every instance.
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 16; i++) begin
        txn(d, 1'b0, 1'b1, pool[i], (pool[i] == 9'h030) ? 32'h12345678 : 32'(pool[i]), 1'b0);
      end
    end

    // One wait state: write then read back.
    txn(1, 1'b0, 1'b1, 9'h010, 32'h4A920000, 1'b0);
    txn(1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);

    // Three wait states: back-to-back reads.
    txn(2, 1'b1, 1'b0, 9'h022, 32'h0, 1'b0);
    check("b2b_first", md[2], 32'h00000022);
    txn(2, 1'b1, 1'b0, 9'h024, 32'h0, 1'b0);
    check("b2b_second", md[2], 32'h00000024);

    // Simultaneous read and write: read wins, Err sticks.
    txn(1, 1'b1, 1'b1, 9'h026, 32'hFFFFFFFF, 1'b0);
    check("simul_data", md[1], 32'h00000026);
    check("simul_err", {31'h0, er[1]}, 32'h1);
    txn(1, 1'b1, 1'b0, 9'h026, 32'h0, 1'b0);
    check("simul_readback", md[1], 32'h00000026);
    txn(1, 1'b0, 1'b1, 9'h02B, 32'h0BADF00D, 1'b0);
    check("err_sticky", {31'h0, er[1]}, 32'h1);

    // Clear during ACK keeps the completed write.
    wr[1] = 1'b1; ad[1] = 9'h02A; dt[1] = 32'hCAFE0001;
    ram_m[1][9'h02A] = 32'hCAFE0001;
    tick();
    tick();
    check("ack_done", {31'h0, dn[1]}, 32'h1);
    #2 Clear = 1'b0;
    #1 check_reset_all();
    wr[1] = 1'b0;
    #2 Clear = 1'b1;
    tick();
    txn(1, 1'b1, 1'b0, 9'h02A, 32'h0, 1'b0);
    check("ack_clear_kept", md[1], 32'hCAFE0001);

    // Four wait states: Clear mid-WAIT aborts the write.
    wr[3] = 1'b1; ad[3] = 9'h030; dt[3] = 32'hDEADBEEF;
    tick();
    tick();
    #2 Clear = 1'b0;
    #1 check_reset_all();
    wr[3] = 1'b0;
    #2 Clear = 1'b1;
    repeat (6) begin
      tick();
      check("abort_no_done", {31'h0, dn[3]}, 32'h0);
    end
    txn(3, 1'b1, 1'b0, 9'h030, 32'h0, 1'b0);
    check("abort_ram_kept", md[3], 32'h12345678);

    // Zero wait states: early release gives a one-cycle Done pulse.
    txn(0, 1'b1, 1'b0, 9'h024, 32'h0, 1'b1);
    check("early_data", md[0], 32'h00000024);

    // Random traffic across all instances.
    for (int k = 0; k < 160; k++) begin
      int d;
      int kind;
      logic [8:0] a;
      d    = $urandom_range(0, 3);
      a    = pool[$urandom_range(0, 15)];
      kind = $urandom_range(0, 9);
      txn(d, kind <= 5, (kind == 0) || (kind > 5), a, $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
